// File: rtl/mmm_pkg.sv
// Shared state encoding and default geometry for the matrix-multiply stream driver.
package mmm_pkg;

  localparam int DEF_ADDRWIDTH   = 2;
  localparam int DEF_SIZE        = 4;
  localparam int DEF_DATAWIDTH   = 8;
  localparam int DEF_WAIT_CYCLES = 2 * DEF_SIZE;

  // Cycles from one element's first ISSUE cycle to the next element's first ISSUE cycle.
  localparam int ELEM_CYCLES = DEF_SIZE + DEF_WAIT_CYCLES + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ENABLE,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mmm_index_counter.sv
// Nested i/j/k matrix index counters: k walks the dot product, j then i walk the result matrix.
module mmm_index_counter
  import mmm_pkg::*;
#(
  parameter int ADDRWIDTH = DEF_ADDRWIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 inc_k_i,
  input  logic                 inc_j_i,
  output logic [ADDRWIDTH-1:0] i_o,
  output logic [ADDRWIDTH-1:0] j_o,
  output logic [ADDRWIDTH-1:0] k_o,
  output logic                 k_last_o,
  output logic                 j_last_o,
  output logic                 i_last_o
);

  logic [ADDRWIDTH-1:0] i_q, i_d;
  logic [ADDRWIDTH-1:0] j_q, j_d;
  logic [ADDRWIDTH-1:0] k_q, k_d;

  assign k_last_o = (k_q == {ADDRWIDTH{1'b1}});
  assign j_last_o = (j_q == {ADDRWIDTH{1'b1}});
  assign i_last_o = (i_q == {ADDRWIDTH{1'b1}});

  assign i_o = i_q;
  assign j_o = j_q;
  assign k_o = k_q;

  // Counters wrap naturally at 2**ADDRWIDTH, so no index ever leaves the matrix.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clear_i) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else begin
      if (inc_k_i) begin
        k_d = k_q + 1'b1;
      end
      if (inc_j_i) begin
        j_d = j_q + 1'b1;
        if (j_last_o) begin
          i_d = i_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/mmm_stream_driver.sv
// Sequences one C = A x B run: streams operand pairs into the MulandAddTree, then
// pulses enable and writes the accumulated result into the C memory.
module mmm_stream_driver
  import mmm_pkg::*;
#(
  parameter int ADDRWIDTH   = DEF_ADDRWIDTH,
  parameter int SIZE        = DEF_SIZE,
  parameter int DATAWIDTH   = DEF_DATAWIDTH,
  parameter int WAIT_CYCLES = 2 * SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [2*ADDRWIDTH-1:0] a_rd_addr,
  input  logic [DATAWIDTH-1:0]   a_rd_data,
  output logic [2*ADDRWIDTH-1:0] b_rd_addr,
  input  logic [DATAWIDTH-1:0]   b_rd_data,
  output logic                   load,
  output logic                   enable,
  output logic [DATAWIDTH-1:0]   in_a,
  output logic [DATAWIDTH-1:0]   in_b,
  input  logic [2*DATAWIDTH-1:0] tree_out,
  output logic                   c_wr_en,
  output logic [2*ADDRWIDTH-1:0] c_wr_addr,
  output logic [2*DATAWIDTH-1:0] c_wr_data
);

  if ((SIZE != (1 << ADDRWIDTH)) || (WAIT_CYCLES < 1)) begin : g_bad_params
    $error("mmm_stream_driver: SIZE must equal 2**ADDRWIDTH and WAIT_CYCLES must be >= 1");
  end

  localparam int WCW = $clog2(WAIT_CYCLES + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_CYCLES - 1);

  state_t         state_q;
  logic [WCW-1:0] wait_q;
  logic           busy_q;
  logic           done_q;
  logic           load_q;
  logic           enable_q;
  logic           c_wr_en_q;

  logic [ADDRWIDTH-1:0] idx_i, idx_j, idx_k;
  logic                 k_last, j_last, i_last;
  logic                 cnt_clear, inc_k, inc_j;

  assign cnt_clear = (state_q == ST_IDLE) && start;
  assign inc_k     = (state_q == ST_ISSUE);
  assign inc_j     = (state_q == ST_WRITE);

  mmm_index_counter #(
    .ADDRWIDTH (ADDRWIDTH)
  ) u_index (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (cnt_clear),
    .inc_k_i  (inc_k),
    .inc_j_i  (inc_j),
    .i_o      (idx_i),
    .j_o      (idx_j),
    .k_o      (idx_k),
    .k_last_o (k_last),
    .j_last_o (j_last),
    .i_last_o (i_last)
  );

  // Strobes are registered for the state being entered, so each is high exactly while in it.
  // load trails ISSUE by one cycle to line up with the sync-read memory data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      load_q    <= 1'b0;
      enable_q  <= 1'b0;
      c_wr_en_q <= 1'b0;
    end else begin
      load_q    <= (state_q == ST_ISSUE);
      done_q    <= 1'b0;
      enable_q  <= 1'b0;
      c_wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_ISSUE;
            busy_q  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (k_last) begin
            state_q <= ST_WAIT;
            wait_q  <= '0;
          end
        end
        ST_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            state_q  <= ST_ENABLE;
            enable_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ST_ENABLE: begin
          state_q   <= ST_WRITE;
          c_wr_en_q <= 1'b1;
        end
        ST_WRITE: begin
          if (i_last && j_last) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign load      = load_q;
  assign enable    = enable_q;
  assign c_wr_en   = c_wr_en_q;

  assign a_rd_addr = {idx_i, idx_k};
  assign b_rd_addr = {idx_k, idx_j};
  assign c_wr_addr = {idx_i, idx_j};

  assign in_a      = a_rd_data;
  assign in_b      = b_rd_data;
  assign c_wr_data = c_wr_en_q ? tree_out : '0;

endmodule

// File: tb/tb_mmm_stream_driver.sv
// Directed bench: two drivers (WAIT_CYCLES 8 and 1) with sync-read memories and a behavioural tree.
module tb_mmm_stream_driver;
  import mmm_pkg::*;

  localparam int SZ = 4;
  localparam int W0 = 8;
  localparam int W1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic        start0 = 1'b0, start1 = 1'b0;
  logic        busy0, done0, load0, enable0, cwe0;
  logic        busy1, done1, load1, enable1, cwe1;
  logic [3:0]  aAddr0, bAddr0, cAddr0, aAddr1, bAddr1, cAddr1;
  logic [7:0]  aData0, bData0, inA0, inB0, aData1, bData1, inA1, inB1;
  logic [15:0] treeOut0, cData0, acc0, treeOut1, cData1, acc1;
  logic [7:0]  memA0 [16];
  logic [7:0]  memB0 [16];
  logic [7:0]  memA1 [16];
  logic [7:0]  memB1 [16];

  mmm_stream_driver #(.ADDRWIDTH(2), .SIZE(SZ), .DATAWIDTH(8), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .a_rd_addr(aAddr0), .a_rd_data(aData0), .b_rd_addr(bAddr0), .b_rd_data(bData0),
    .load(load0), .enable(enable0), .in_a(inA0), .in_b(inB0), .tree_out(treeOut0),
    .c_wr_en(cwe0), .c_wr_addr(cAddr0), .c_wr_data(cData0)
  );

  mmm_stream_driver #(.ADDRWIDTH(2), .SIZE(SZ), .DATAWIDTH(8), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .a_rd_addr(aAddr1), .a_rd_data(aData1), .b_rd_addr(bAddr1), .b_rd_data(bData1),
    .load(load1), .enable(enable1), .in_a(inA1), .in_b(inB1), .tree_out(treeOut1),
    .c_wr_en(cwe1), .c_wr_addr(cAddr1), .c_wr_data(cData1)
  );

  // Sync-read memories and a tree that accumulates on load and hands over and clears on enable.
  always @(posedge clk) begin
    aData0 <= memA0[aAddr0];
    bData0 <= memB0[bAddr0];
    aData1 <= memA1[aAddr1];
    bData1 <= memB1[bAddr1];
    if (rst) begin
      acc0 <= '0; treeOut0 <= '0; acc1 <= '0; treeOut1 <= '0;
    end else begin
      if (enable0) begin treeOut0 <= acc0; acc0 <= '0; end
      else if (load0) acc0 <= acc0 + ({8'd0, inA0} * {8'd0, inB0});
      if (enable1) begin treeOut1 <= acc1; acc1 <= '0; end
      else if (load1) acc1 <= acc1 + ({8'd0, inA1} * {8'd0, inB1});
    end
  end

  int wrCnt0 = 0, doneCnt0 = 0, doneCyc0 = 0, loadRun0 = 0, lastLoadCyc0 = 0, enCyc0 = 0;
  int runBad0 = 0, gapBad0 = 0, overlap0 = 0, orderBad0 = 0, xBad0 = 0, lastWr0 = -1, periodBad0 = 0;
  logic [3:0]  expAddr0 = '0;
  logic [15:0] capC0 [16];
  logic        wrMask0 [16];

  int wrCnt1 = 0, doneCnt1 = 0, doneCyc1 = 0, lastWr1 = -1, periodBad1 = 0, overlap1 = 0;
  logic [15:0] capC1 [16];

  // Protocol monitors sample mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (done0) begin doneCnt0++; doneCyc0 = cyc; end
    if (load0 && enable0) overlap0++;
    if (load0) begin
      loadRun0++;
      lastLoadCyc0 = cyc;
    end else if (loadRun0 != 0) begin
      if (loadRun0 != SZ) runBad0++;
      loadRun0 = 0;
    end
    if (enable0) begin
      if (cyc - lastLoadCyc0 != W0) gapBad0++;
      enCyc0 = cyc;
    end
    if (cwe0) begin
      if (cyc != enCyc0 + 1) gapBad0++;
      if (cAddr0 != expAddr0) orderBad0++;
      if (lastWr0 >= 0 && cyc - lastWr0 != ELEM_CYCLES) periodBad0++;
      if ($isunknown(cData0)) xBad0++;
      lastWr0 = cyc;
      expAddr0 = expAddr0 + 4'd1;
      capC0[cAddr0] = cData0;
      wrMask0[cAddr0] = 1'b1;
      wrCnt0++;
    end
  end

  always @(negedge clk) begin
    if (done1) begin doneCnt1++; doneCyc1 = cyc; end
    if (load1 && enable1) overlap1++;
    if (cwe1) begin
      if (lastWr1 >= 0 && cyc - lastWr1 != 7) periodBad1++;
      lastWr1 = cyc;
      capC1[cAddr1] = cData1;
      wrCnt1++;
    end
  end

  int issueCyc = 0;
  int prevDone = 0;
  logic [15:0] gold [16];
  logic [15:0] sum;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int which);
    @(negedge clk);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    issueCyc = cyc;
  endtask

  task automatic waitDone(input int which, input int budget);
    int prev;
    int n;
    prev = (which == 0) ? doneCnt0 : doneCnt1;
    n = 0;
    while (((which == 0) ? doneCnt0 : doneCnt1) == prev && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen_in_budget", 32'(((which == 0) ? doneCnt0 : doneCnt1) != prev), 32'd1);
  endtask

  task automatic clearRun0();
    wrCnt0 = 0;
    expAddr0 = '0;
    lastWr0 = -1;
    for (int n = 0; n < 16; n++) begin
      capC0[n] = 'x;
      wrMask0[n] = 1'b0;
    end
  endtask

  task automatic computeGold0();
    for (int i = 0; i < SZ; i++) begin
      for (int j = 0; j < SZ; j++) begin
        sum = '0;
        for (int k = 0; k < SZ; k++) sum = sum + ({8'd0, memA0[i*4+k]} * {8'd0, memB0[k*4+j]});
        gold[i*4+j] = sum;
      end
    end
  endtask

  task automatic checkAllC0(input string pfx);
    for (int n = 0; n < 16; n++) checkOutput($sformatf("%s_C[%0d][%0d]", pfx, n / 4, n % 4), 32'(capC0[n]), 32'(gold[n]));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < SZ; i++) begin
      for (int j = 0; j < SZ; j++) begin
        memA0[i*4+j] = 8'(i * j + 1);
        memB0[i*4+j] = 8'(i * j + 2);
        memA1[i*4+j] = (i == j) ? 8'd1 : 8'd0;
        memB1[i*4+j] = 8'(i * 4 + j);
        capC1[i*4+j] = 'x;
      end
    end
    clearRun0();

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy0), 32'd0);
    checkOutput("rst_done", 32'(done0), 32'd0);
    checkOutput("rst_load", 32'(load0), 32'd0);
    checkOutput("rst_enable", 32'(enable0), 32'd0);
    checkOutput("rst_c_wr_en", 32'(cwe0), 32'd0);
    checkOutput("rst_a_addr", 32'(aAddr0), 32'd0);
    checkOutput("rst_b_addr", 32'(bAddr0), 32'd0);
    checkOutput("rst_c_addr", 32'(cAddr0), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full run with an ignored start at cycle 50.
    prevDone = doneCnt0;
    applyStimulus(0);
    checkOutput("busy_after_start", 32'(busy0), 32'd1);
    while (cyc < issueCyc + 50) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    waitDone(0, 400);
    checkOutput("run1_done_latency", 32'(doneCyc0 - issueCyc), 32'd224);
    checkOutput("run1_busy_low_at_done", 32'(busy0), 32'd0);
    repeat (40) @(negedge clk);
    checkOutput("run1_single_done", 32'(doneCnt0 - prevDone), 32'd1);
    checkOutput("run1_no_restart", 32'(busy0), 32'd0);
    checkOutput("run1_writes", 32'(wrCnt0), 32'd16);
    checkOutput("run1_C00", 32'(capC0[0]), 32'd8);
    checkOutput("run1_C11", 32'(capC0[5]), 32'd40);
    checkOutput("run1_C33", 32'(capC0[15]), 32'd188);
    computeGold0();
    checkAllC0("run1");
    checkOutput("run1_load_runs", 32'(runBad0), 32'd0);
    checkOutput("run1_gaps", 32'(gapBad0), 32'd0);
    checkOutput("run1_overlap", 32'(overlap0), 32'd0);
    checkOutput("run1_order", 32'(orderBad0), 32'd0);
    checkOutput("run1_period", 32'(periodBad0), 32'd0);

    // Reset during the WAIT of element (1,2).
    clearRun0();
    applyStimulus(0);
    while (cyc < issueCyc + 6 * 14 + 6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", 32'(busy0), 32'd0);
    checkOutput("midrst_load", 32'(load0), 32'd0);
    checkOutput("midrst_enable", 32'(enable0), 32'd0);
    checkOutput("midrst_c_wr_en", 32'(cwe0), 32'd0);
    checkOutput("midrst_a_addr", 32'(aAddr0), 32'd0);
    checkOutput("midrst_b_addr", 32'(bAddr0), 32'd0);
    repeat (30) @(negedge clk);
    checkOutput("midrst_writes", 32'(wrCnt0), 32'd6);
    checkOutput("midrst_no_write_1_2", 32'(wrMask0[6]), 32'd0);
    checkOutput("midrst_stays_idle", 32'(busy0), 32'd0);
    clearRun0();
    applyStimulus(0);
    waitDone(0, 400);
    @(negedge clk);
    checkOutput("rerun_writes", 32'(wrCnt0), 32'd16);
    checkAllC0("rerun");

    // WAIT_CYCLES=1 instance: identity A, so C equals B.
    applyStimulus(1);
    waitDone(1, 300);
    @(negedge clk);
    checkOutput("w1_done_latency", 32'(doneCyc1 - issueCyc), 32'd112);
    checkOutput("w1_writes", 32'(wrCnt1), 32'd16);
    checkOutput("w1_period", 32'(periodBad1), 32'd0);
    checkOutput("w1_overlap", 32'(overlap1), 32'd0);
    for (int n = 0; n < 16; n++) checkOutput($sformatf("w1_C[%0d][%0d]", n / 4, n % 4), 32'(capC1[n]), 32'(n));

    // Saturated operands: 4*255*255 truncated to 16 bits.
    for (int n = 0; n < 16; n++) begin
      memA0[n] = 8'hFF;
      memB0[n] = 8'hFF;
    end
    clearRun0();
    applyStimulus(0);
    waitDone(0, 400);
    @(negedge clk);
    checkOutput("max_writes", 32'(wrCnt0), 32'd16);
    checkOutput("max_x_on_data", 32'(xBad0), 32'd0);
    for (int n = 0; n < 16; n++) checkOutput($sformatf("max_C[%0d][%0d]", n / 4, n % 4), 32'(capC0[n]), 32'h0000F804);
    checkOutput("all_load_runs", 32'(runBad0), 32'd0);
    checkOutput("all_gaps", 32'(gapBad0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
